// File: rtl/sigma_mem_pkg.sv
// sigma_mem_pkg: shared state encoding and sizing constants for the Sigma wait-state memory.
`default_nettype none

package sigma_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int BYTE_WIDTH = 8;
  localparam int CNT_WIDTH  = 4;

endpackage

`default_nettype wire

// File: rtl/sigma_mem_array.sv
// sigma_mem_array: DEPTH x DATA_WIDTH storage, byte-lane synchronous write, combinational read.
`default_nettype none

module sigma_mem_array
  import sigma_mem_pkg::*;
#(
  parameter int DEPTH      = 128,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 7
) (
  input  logic                             i_clk,
  input  logic                             i_we,
  input  logic [0:DATA_WIDTH/BYTE_WIDTH-1] i_be,
  input  logic [IDX_W-1:0]                 i_idx,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam int c_NB = DATA_WIDTH / BYTE_WIDTH;

  logic [DATA_WIDTH-1:0] ram_cells [DEPTH];

  // Lane 0 is the most significant byte of the word.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int i = 0; i < c_NB; i++) begin
        if (i_be[i]) begin
          ram_cells[i_idx][DATA_WIDTH-1-BYTE_WIDTH*i -: BYTE_WIDTH] <=
            i_wdata[DATA_WIDTH-1-BYTE_WIDTH*i -: BYTE_WIDTH];
        end
      end
    end
  end

  assign o_rdata = ram_cells[i_idx];

endmodule

`default_nettype wire

// File: rtl/sigma_wait_memory.sv
// sigma_wait_memory: word RAM behind a req/ack handshake with programmable wait states
// and selectable out-of-range policy (masking or fault).
`default_nettype none

module sigma_wait_memory
  import sigma_mem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_STATES = 2,
  parameter int FAULT_MODE  = 0
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_req,
  input  logic                             i_write_en,
  input  logic [ADDR_WIDTH-1:0]            i_address,
  input  logic [0:DATA_WIDTH/BYTE_WIDTH-1] i_byte_en,
  input  logic [DATA_WIDTH-1:0]            i_data_in,
  output logic                             o_busy,
  output logic                             o_ack,
  output logic                             o_fault,
  output logic [DATA_WIDTH-1:0]            o_data_out
);

  localparam int c_NB    = DATA_WIDTH / BYTE_WIDTH;
  localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_WIDTH-1:0] c_WS_LOAD =
    (WAIT_STATES > 0) ? CNT_WIDTH'(WAIT_STATES - 1) : '0;

  state_t                 r_state, w_next;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_next;
  logic                   r_we;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [0:c_NB-1]        r_be;
  logic [DATA_WIDTH-1:0]  r_wdata;
  logic                   r_busy, r_ack, r_fault;
  logic [DATA_WIDTH-1:0]  r_data_out;

  logic [ADDR_WIDTH-1:0]  w_acc_addr;
  logic                   w_acc_we;
  logic [c_IDX_W-1:0]     w_idx;
  logic                   w_hi;
  logic                   w_oor;
  logic                   w_enter_done;
  logic                   w_ram_we;
  logic [DATA_WIDTH-1:0]  w_rdata;

  // With zero wait states the access completes on the acceptance edge, so the
  // live inputs must feed the array directly while idle.
  assign w_acc_addr = (r_state == ST_IDLE) ? i_address  : r_addr;
  assign w_acc_we   = (r_state == ST_IDLE) ? i_write_en : r_we;
  assign w_idx      = w_acc_addr[c_IDX_W-1:0];

  generate
    if (ADDR_WIDTH > c_IDX_W) begin : g_hi_bits
      assign w_hi = |w_acc_addr[ADDR_WIDTH-1:c_IDX_W];
    end else begin : g_no_hi_bits
      assign w_hi = 1'b0;
    end
  endgenerate

  assign w_oor = (FAULT_MODE != 0) && w_hi;

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (i_req) begin
          if (WAIT_STATES > 0) begin
            w_next     = ST_WAIT;
            w_cnt_next = c_WS_LOAD;
          end else begin
            w_next = ST_DONE;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == '0) begin
          w_next = ST_DONE;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_enter_done = (w_next == ST_DONE) && (r_state != ST_DONE);
  assign w_ram_we     = (r_state == ST_DONE) && r_we && !w_oor;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
    end else if (r_state == ST_IDLE && i_req) begin
      r_we    <= i_write_en;
      r_addr  <= i_address;
      r_be    <= i_byte_en;
      r_wdata <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy     <= 1'b0;
      r_ack      <= 1'b0;
      r_fault    <= 1'b0;
      r_data_out <= '0;
    end else begin
      r_busy  <= (w_next != ST_IDLE);
      r_ack   <= w_enter_done;
      r_fault <= w_enter_done && w_oor;
      if (w_enter_done && !w_acc_we) begin
        r_data_out <= w_oor ? '0 : w_rdata;
      end
    end
  end

  sigma_mem_array #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (c_IDX_W)
  ) ram (
    .i_clk   (i_clk),
    .i_we    (w_ram_we),
    .i_be    (r_be),
    .i_idx   (w_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign o_busy     = r_busy;
  assign o_ack      = r_ack;
  assign o_fault    = r_fault;
  assign o_data_out = r_data_out;

endmodule

`default_nettype wire

// File: tb/tb_sigma_wait_memory.sv
// tb_sigma_wait_memory: three configurations of sigma_wait_memory against a word-array reference model.
`default_nettype none

module tb_sigma_wait_memory;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [2:0]       req_v = 3'b000;
  logic             write_en = 1'b0;
  logic [16:0]      addr = '0;
  logic [0:3]       byte_en = '0;
  logic [31:0]      data_in = '0;
  logic [2:0]       busy_v, ack_v, fault_v;
  logic [2:0][31:0] dout_v;

  logic [31:0] mem [3][128];
  logic [31:0] exp_dout [3];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sigma_wait_memory #(.WAIT_STATES(2), .FAULT_MODE(0)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_v[0]), .i_write_en(write_en),
    .i_address(addr), .i_byte_en(byte_en), .i_data_in(data_in),
    .o_busy(busy_v[0]), .o_ack(ack_v[0]), .o_fault(fault_v[0]), .o_data_out(dout_v[0]));

  sigma_wait_memory #(.WAIT_STATES(0), .FAULT_MODE(1)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_v[1]), .i_write_en(write_en),
    .i_address(addr), .i_byte_en(byte_en), .i_data_in(data_in),
    .o_busy(busy_v[1]), .o_ack(ack_v[1]), .o_fault(fault_v[1]), .o_data_out(dout_v[1]));

  sigma_wait_memory #(.WAIT_STATES(15), .FAULT_MODE(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req_v[2]), .i_write_en(write_en),
    .i_address(addr), .i_byte_en(byte_en), .i_data_in(data_in),
    .o_busy(busy_v[2]), .o_ack(ack_v[2]), .o_fault(fault_v[2]), .o_data_out(dout_v[2]));

  function automatic int ws_of(input int s);
    return (s == 0) ? 2 : (s == 1) ? 0 : 15;
  endfunction

  function automatic bit fm_of(input int s);
    return (s == 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete access on instance s; inputs are driven just after a rising edge.
  task automatic xact(input int s, input bit we, input logic [16:0] a,
                      input logic [0:3] be, input logic [31:0] d);
    int  n;
    bit  oor;
    int  idx;
    logic [31:0] w;
    addr = a; write_en = we; byte_en = be; data_in = d;
    req_v[s] = 1'b1;
    @(posedge clk); #1;
    req_v[s] = 1'b0;
    chk($sformatf("busy_accept[%0d]", s), busy_v[s], 1);
    n = 0;
    while (ack_v[s] !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("latency[%0d]", s), n, ws_of(s));
    oor = fm_of(s) && (a >= 17'd128);
    idx = int'(a % 17'd128);
    if (!we) begin
      exp_dout[s] = oor ? 32'h0 : mem[s][idx];
    end else if (!oor) begin
      w = mem[s][idx];
      for (int i = 0; i < 4; i++)
        if (be[i]) w[31-8*i -: 8] = d[31-8*i -: 8];
      mem[s][idx] = w;
    end
    chk($sformatf("fault[%0d]", s), fault_v[s], oor);
    chk($sformatf("data_out[%0d]", s), dout_v[s], exp_dout[s]);
    chk($sformatf("busy_done[%0d]", s), busy_v[s], 1);
    @(posedge clk); #1;
    chk($sformatf("ack_clear[%0d]", s), ack_v[s], 0);
    chk($sformatf("busy_clear[%0d]", s), busy_v[s], 0);
    chk($sformatf("fault_clear[%0d]", s), fault_v[s], 0);
  endtask

  // req held high for a whole number of access periods; one ack per period.
  task automatic burst(input int s, input logic [16:0] a, input int periods);
    int p;
    int acks;
    bit ea;
    p = ws_of(s) + 2;
    acks = 0;
    addr = a; write_en = 1'b0; byte_en = 4'b0000;
    exp_dout[s] = mem[s][int'(a % 17'd128)];
    req_v[s] = 1'b1;
    for (int k = 0; k < periods * p; k++) begin
      @(posedge clk); #1;
      ea = ((k % p) == ws_of(s));
      chk($sformatf("burst_ack[%0d] k=%0d", s, k), ack_v[s], ea);
      if (ack_v[s] === 1'b1) acks++;
      if (ea) chk($sformatf("burst_data[%0d]", s), dout_v[s], exp_dout[s]);
    end
    req_v[s] = 1'b0;
    chk($sformatf("burst_count[%0d]", s), acks, periods);
  endtask

  initial begin
    for (int s = 0; s < 3; s++) exp_dout[s] = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset_busy[%0d]", s), busy_v[s], 0);
      chk($sformatf("reset_ack[%0d]", s), ack_v[s], 0);
      chk($sformatf("reset_fault[%0d]", s), fault_v[s], 0);
      chk($sformatf("reset_data[%0d]", s), dout_v[s], 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Preload every word through the port with full-lane writes.
    for (int s = 0; s < 3; s++)
      for (int w = 0; w < 128; w++)
        xact(s, 1'b1, 17'(w), 4'b1111, $urandom);

    // Plain read with two wait states.
    xact(0, 1'b1, 17'd5, 4'b1111, 32'hDEADBEEF);
    xact(0, 1'b0, 17'd5, 4'b0000, 32'h0);
    chk("t1_data", dout_v[0], 32'hDEADBEEF);

    // Byte-lane write, lane 0 = MSB.
    xact(0, 1'b1, 17'd3, 4'b1111, 32'hAABBCCDD);
    xact(0, 1'b1, 17'd3, 4'b1010, 32'h11223344);
    xact(0, 1'b0, 17'd3, 4'b0000, 32'h0);
    chk("t2_data", dout_v[0], 32'h11BB33DD);
    xact(0, 1'b1, 17'd3, 4'b0000, 32'hFFFFFFFF);
    xact(0, 1'b0, 17'd3, 4'b0000, 32'h0);
    chk("t2_noop", dout_v[0], 32'h11BB33DD);

    // Out-of-range: masked on instance 0, faulting on instance 1.
    xact(0, 1'b0, 17'h85, 4'b0000, 32'h0);
    chk("t3_mask", dout_v[0], 32'hDEADBEEF);
    xact(1, 1'b1, 17'd5, 4'b1111, 32'h5A5A1234);
    xact(1, 1'b0, 17'h85, 4'b0000, 32'h0);
    xact(1, 1'b1, 17'h85, 4'b1111, 32'h0BADF00D);
    xact(1, 1'b0, 17'd5, 4'b0000, 32'h0);
    chk("t3_unchanged", dout_v[1], 32'h5A5A1234);

    // Continuous req: ignored while busy, one ack per period.
    burst(1, 17'd9, 5);
    burst(0, 17'd10, 3);

    // Abort a write with reset during its wait states.
    xact(0, 1'b0, 17'd7, 4'b0000, 32'h0);
    addr = 17'd7; write_en = 1'b1; byte_en = 4'b1111; data_in = ~mem[0][7];
    req_v[0] = 1'b1;
    @(posedge clk); #1;
    req_v[0] = 1'b0;
    @(posedge clk); #1;
    chk("t5_busy_before", busy_v[0], 1);
    rst_n = 1'b0;
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("t5_busy[%0d]", s), busy_v[s], 0);
      chk($sformatf("t5_ack[%0d]", s), ack_v[s], 0);
      chk($sformatf("t5_fault[%0d]", s), fault_v[s], 0);
      chk($sformatf("t5_data[%0d]", s), dout_v[s], 0);
      exp_dout[s] = 32'h0;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    xact(0, 1'b0, 17'd7, 4'b0000, 32'h0);

    // Longest wait setting.
    xact(2, 1'b0, 17'd20, 4'b0000, 32'h0);
    xact(2, 1'b1, 17'd21, 4'b0110, 32'hCAFEF00D);
    xact(2, 1'b0, 17'd21, 4'b0000, 32'h0);

    // Random traffic against the model.
    for (int t = 0; t < 150; t++) begin
      int s;
      s = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
      xact(s, 1'($urandom_range(0, 1)), 17'($urandom_range(0, 255)),
           4'($urandom_range(0, 15)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/sigma_wait_memory.md
Name: sigma_wait_memory

Overview:
- Parametrised successor to the bench memory used by the Sigma CPU test bench.
- Word-addressed RAM behind a request/acknowledge handshake with configurable wait states, per-byte write enables, and selectable out-of-range policy: address masking or fault reporting.
- Sits between CPU and storage in simulation and on FPGA builds; lets microcode be exercised against slow memory.

Parameters:
- ADDR_WIDTH, 17, width of the word address; bit order [15:31] style, MSB first.
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- DEPTH, 128, number of words; power of two.
- WAIT_STATES, 2, extra cycles between request acceptance and acknowledge (0..15).
- FAULT_MODE, 0, 0 = address masked by DEPTH-1; 1 = address >= DEPTH faults.

Ports:
- clock  in  1  system clock, posedge active.
- reset  in  1  asynchronous, active-low reset.
- req  in  1  request strobe, sampled only in IDLE.
- write_en  in  1  1 = write, 0 = read; sampled with req.
- address  in  ADDR_WIDTH  word address; sampled with req.
- byte_en  in  DATA_WIDTH/8  byte lane write enables, bit 0 = most significant byte; sampled with req.
- data_in  in  DATA_WIDTH  write data; sampled with req.
- busy  out  1  high while a request is in flight (state != IDLE).
- ack  out  1  one-cycle completion pulse.
- fault  out  1  valid with ack; 1 = out-of-range access.
- data_out  out  DATA_WIDTH  read data, registered, valid with ack, held until next ack.

Behaviour:
- Reset is asynchronous while reset=0. State becomes IDLE; busy=0, ack=0, fault=0, data_out=0; wait counter=0; latched request cleared. Array contents are not reset; they are loaded via $readmemh on the array instance.
- States:
  - IDLE: if req=1 at posedge, latch write_en/address/byte_en/data_in. Then go to WAIT (WAIT_STATES>0, counter loaded with WAIT_STATES-1) or to DONE (WAIT_STATES=0).
  - WAIT: decrement counter each cycle; at 0 go to DONE.
  - DONE: perform access, pulse ack for exactly this cycle, return to IDLE.
- Latency: ack is high in cycle N+WAIT_STATES+1, where N is the req sampling edge. A back-to-back req is accepted on the first edge in IDLE, so throughput is one access per WAIT_STATES+2 cycles.
- busy is registered: high from the edge after acceptance through the DONE cycle inclusive.
- req while busy is ignored, not queued. The requester must hold req until it observes busy=1, or drop it after one edge in IDLE.
- Write: committed on the posedge ending DONE. Only lanes with byte_en=1 are updated. byte_en=0 everywhere is a legal no-op write that still acks. data_out is unchanged on writes.
- Read: data_out is loaded on the edge entering DONE from the array word at the latched address, so it is valid during the ack cycle.
- Range, FAULT_MODE=0: effective index = address & (DEPTH-1); fault is always 0.
- Range, FAULT_MODE=1, address >= DEPTH: no write, data_out loaded with 0, fault=1 with ack, same latency as a normal access.
- fault is 0 whenever ack=0.
- Reset mid-operation (WAIT or DONE before the commit edge) aborts: no write, no ack.
- Reads return the value before any write in the same cycle; there is a single port, so simultaneous read and write cannot occur.

Decomposition:
- Package sigma_mem_pkg: state encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2), BYTE_WIDTH=8, counter width constant (4).
- Sub-module sigma_mem_array: DEPTH x DATA_WIDTH storage with synchronous byte-enabled write and combinational read. The instance is named ram so benches can reach ram.ram_cells for $readmemh.
- The controller FSM, counter and range check live in sigma_wait_memory.

Test Plan:
1. WAIT_STATES=2, preload word 5=32'hDEADBEEF. Read addr 5 at edge 0 -> busy 1 on edges 1-3, ack+data_out=32'hDEADBEEF on cycle 3, fault=0.
2. Write addr 3, data 32'h11223344, byte_en=4'b1010, word 3 previously 32'hAABBCCDD -> later read returns 32'h11BB33DD.
3. FAULT_MODE=0, DEPTH=128, read addr 17'h85 -> returns word 5. FAULT_MODE=1, same read -> ack with fault=1, data_out=0. Write to addr 17'h85 leaves word 5 unchanged.
4. req held high continuously, WAIT_STATES=0 -> ack every 2nd cycle. req pulses during busy are ignored: exactly one ack per acceptance.
5. Assert reset low during WAIT of a write to addr 7 -> busy, ack, fault and data_out drop to 0 immediately (asynchronously). Word 7 is unchanged after reset release.
6. WAIT_STATES=15 -> ack exactly 16 cycles after acceptance. Counter does not wrap; busy stays high for 16 cycles.
